// File: rtl/jt51_timer_pkg.sv
// Shared limits, encodings and helpers for the jt51 timer bank.
package jt51_timer_pkg;

   localparam int MAX_NTIMER = 8;
   localparam int MIN_CW     = 2;
   localparam int MAX_CW     = 16;
   localparam int MAX_PW     = 12;

   typedef enum logic {
      MODE_RELOAD  = 1'b0,
      MODE_ONESHOT = 1'b1
   } timer_mode_e;

   typedef enum logic {
      SRC_TICK    = 1'b0,
      SRC_CASCADE = 1'b1
   } count_src_e;

   // Narrowest select width able to address n channels.
   function automatic int sel_min_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/jt51_timer_ch.sv
// One timer channel: start register, prescaler and counter kept as a single
// {cnt,pre} accumulator, run and sticky overflow flag.
module jt51_timer_ch
   import jt51_timer_pkg::*;
#(
   parameter int CW = 10,
   parameter int PW = 6
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen_i,
   input  logic          load_i,
   input  logic [CW-1:0] value_i,
   input  logic          set_run_i,
   input  logic          clr_run_i,
   input  logic          clr_flag_i,
   input  logic          oneshot_i,
   input  logic          casc_sel_i,
   input  logic          casc_tick_i,
   output logic [CW-1:0] cnt_o,
   output logic          flag_o,
   output logic          overflow_o,
   output logic          wrap_o
);

   localparam int AW = CW + PW;

   logic [CW-1:0] start_q, start_d;
   logic [AW-1:0] acc_q, acc_d;
   logic          run_q, run_d;
   logic          flag_q, flag_d;
   logic          ovf_q;

   timer_mode_e   mode;
   count_src_e    src;
   logic [AW-1:0] step;
   logic          tick;
   logic          wrap;

   assign mode = timer_mode_e'(oneshot_i);
   assign src  = casc_sel_i ? SRC_CASCADE : SRC_TICK;

   // A cascaded channel bypasses its prescaler: it steps the counter field directly.
   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch;
      // combinational logic uses blocking assignments.
      step    = (src == SRC_CASCADE) ? (AW'(1) << PW) : AW'(1);
      tick    = run_q & ~load_i & ((src == SRC_CASCADE) ? casc_tick_i : cen_i);
      wrap    = tick & ((src == SRC_CASCADE) ? (&acc_q[AW-1:PW]) : (&acc_q));
      start_d = start_q;
      acc_d   = acc_q;
      if (load_i) begin
         start_d = value_i;
         acc_d   = AW'(value_i) << PW;
      end else if (wrap) begin
         acc_d   = AW'(start_q) << PW;
      end else if (tick) begin
         acc_d   = acc_q + step;
      end
   end

   always_comb begin
      run_d = run_q;
      if (clr_run_i) begin
         run_d = 1'b0;
      end else if (set_run_i || load_i) begin
         run_d = 1'b1;
      end else if (wrap && (mode == MODE_ONESHOT)) begin
         run_d = 1'b0;
      end
      // A wrap in the same cycle as a clear must not be lost.
      flag_d = wrap | (flag_q & ~clr_flag_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         start_q <= '0;
         acc_q   <= '0;
         run_q   <= 1'b0;
         flag_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         start_q <= start_d;
         acc_q   <= acc_d;
         run_q   <= run_d;
         flag_q  <= flag_d;
         ovf_q   <= wrap;
      end
   end

   assign cnt_o      = acc_q[AW-1:PW];
   assign flag_o     = flag_q;
   assign overflow_o = ovf_q;
   assign wrap_o     = wrap;

endmodule

// File: rtl/jt51_timer_bank.sv
// N-channel prescaled timer bank: channel select decode, counter read mux,
// cascade chaining (JT51_TIMER_CASCADE_EN) and wired active-low IRQ.
module jt51_timer_bank
   import jt51_timer_pkg::*;
#(
   parameter int NTIMER = 2,
   parameter int CW     = 10,
   parameter int PW     = 6,
   parameter int SELW   = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cen,
   input  logic [SELW-1:0]   sel,
   input  logic [CW-1:0]     value,
   input  logic              load,
   input  logic [NTIMER-1:0] set_run,
   input  logic [NTIMER-1:0] clr_run,
   input  logic [NTIMER-1:0] clr_flag,
   input  logic [NTIMER-1:0] oneshot,
   input  logic [NTIMER-1:0] irq_en,
   input  logic [NTIMER-1:0] cascade,
   output logic [NTIMER-1:0] flag,
   output logic [NTIMER-1:0] overflow,
   output logic [CW-1:0]     cnt_rd,
   output logic              irq_n
);

   if (NTIMER < 1 || NTIMER > MAX_NTIMER || CW < MIN_CW || CW > MAX_CW ||
       PW < 0 || PW > MAX_PW || SELW < sel_min_width(NTIMER)) begin : g_bad_params
      $error("jt51_timer_bank: parameter out of range");
   end

   logic [NTIMER-1:0] ld_vec;
   logic [NTIMER-1:0] wrap_vec;
   logic [CW-1:0]     cnt_arr [NTIMER];
   logic              unused_bits;

   for (genvar i = 0; i < NTIMER; i++) begin : g_ch
      logic casc_sel_w;
      logic casc_tick_w;

      assign ld_vec[i] = load && (sel == SELW'(i));

      if (i == 0) begin : g_head
         assign casc_sel_w  = 1'b0;
         assign casc_tick_w = 1'b0;
      end else begin : g_link
`ifdef JT51_TIMER_CASCADE_EN
         assign casc_sel_w  = cascade[i];
`else
         assign casc_sel_w  = 1'b0;
`endif
         // Same-edge chaining: the previous channel's combinational wrap is the tick.
         assign casc_tick_w = wrap_vec[i-1];
      end

      jt51_timer_ch #(
         .CW (CW),
         .PW (PW)
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .cen_i       (cen),
         .load_i      (ld_vec[i]),
         .value_i     (value),
         .set_run_i   (set_run[i]),
         .clr_run_i   (clr_run[i]),
         .clr_flag_i  (clr_flag[i]),
         .oneshot_i   (oneshot[i]),
         .casc_sel_i  (casc_sel_w),
         .casc_tick_i (casc_tick_w),
         .cnt_o       (cnt_arr[i]),
         .flag_o      (flag[i]),
         .overflow_o  (overflow[i]),
         .wrap_o      (wrap_vec[i])
      );
   end

`ifdef JT51_TIMER_CASCADE_EN
   assign unused_bits = ^{wrap_vec[NTIMER-1], cascade[0]};
`else
   assign unused_bits = ^{wrap_vec[NTIMER-1], cascade};
`endif

   // Out-of-range selects read back as zero.
   always_comb begin
      cnt_rd = '0;
      for (int i = 0; i < NTIMER; i++) begin
         if (sel == SELW'(i)) cnt_rd = cnt_arr[i];
      end
   end

   assign irq_n = ~|(flag & irq_en);

endmodule

// File: tb/tb_jt51_timer_bank.sv
// Self-checking bench: two banks (PW=6 and PW=0) share stimulus; an arithmetic
// period model is compared every cycle, plus hand-computed timing checks.
module tb_jt51_timer_bank;

   localparam int CW = 10;
`ifdef JT51_TIMER_CASCADE_EN
   localparam bit CASC_EN = 1'b1;
`else
   localparam bit CASC_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cen;
   logic [2:0] sel;
   logic [9:0] value;
   logic       load;
   logic [1:0] set_run, clr_run, clr_flag, oneshot, irq_en, cascade;

   logic [1:0] flag_w [2];
   logic [1:0] ovf_w  [2];
   logic [9:0] cnt_w  [2];
   logic       irqn_w [2];

   int n_pass  = 0;
   int n_total = 0;
   bit chk_en  = 1'b0;

   always #5 clk = ~clk;

   jt51_timer_bank #(.NTIMER(2), .CW(CW), .PW(6), .SELW(3)) dut_a (
      .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .value(value), .load(load),
      .set_run(set_run), .clr_run(clr_run), .clr_flag(clr_flag), .oneshot(oneshot),
      .irq_en(irq_en), .cascade(cascade), .flag(flag_w[0]), .overflow(ovf_w[0]),
      .cnt_rd(cnt_w[0]), .irq_n(irqn_w[0]));

   jt51_timer_bank #(.NTIMER(2), .CW(CW), .PW(0), .SELW(3)) dut_b (
      .clk(clk), .rst_n(rst_n), .cen(cen), .sel(sel), .value(value), .load(load),
      .set_run(set_run), .clr_run(clr_run), .clr_flag(clr_flag), .oneshot(oneshot),
      .irq_en(irq_en), .cascade(cascade), .flag(flag_w[1]), .overflow(ovf_w[1]),
      .cnt_rd(cnt_w[1]), .irq_n(irqn_w[1]));

   task automatic check(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic int pw_of(input int k);
      return (k == 0) ? 6 : 0;
   endfunction

   // Model: each channel's position counted in prescaled ticks; period from start.
   int unsigned m_pos   [2][2];
   int unsigned m_start [2][2];
   bit          m_run   [2][2];
   bit          m_flag  [2][2];
   bit          m_ovf   [2][2];

   always @(posedge clk or negedge rst_n) begin
      int unsigned unit, total, nxt;
      bit casc, ld, tk, w, w_prev;
      if (!rst_n) begin
         for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 2; c++) begin
               m_pos[k][c] = 0; m_start[k][c] = 0; m_run[k][c] = 0;
               m_flag[k][c] = 0; m_ovf[k][c] = 0;
            end
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            unit   = 1 << pw_of(k);
            total  = 1 << (CW + pw_of(k));
            w_prev = 1'b0;
            for (int c = 0; c < 2; c++) begin
               casc = CASC_EN && (c > 0) && cascade[c];
               ld   = load && (int'(sel) == c);
               tk   = m_run[k][c] && !ld && (casc ? w_prev : cen);
               w    = 1'b0;
               if (ld) begin
                  m_start[k][c] = int'(value);
                  m_pos[k][c]   = int'(value) * unit;
               end else if (tk) begin
                  nxt = m_pos[k][c] + (casc ? unit : 1);
                  if (nxt >= total) begin
                     w = 1'b1;
                     m_pos[k][c] = m_start[k][c] * unit;
                  end else begin
                     m_pos[k][c] = nxt;
                  end
               end
               if (clr_run[c])                m_run[k][c] = 1'b0;
               else if (set_run[c] || ld)     m_run[k][c] = 1'b1;
               else if (w && oneshot[c])      m_run[k][c] = 1'b0;
               m_flag[k][c] = w || (m_flag[k][c] && !clr_flag[c]);
               m_ovf[k][c]  = w;
               w_prev       = w;
            end
         end
      end
   end

   always @(negedge clk) begin
      int exp_cnt;
      bit exp_irqn;
      if (chk_en) begin
         for (int k = 0; k < 2; k++) begin
            exp_cnt  = (sel < 2) ? int'(m_pos[k][sel] >> pw_of(k)) : 0;
            exp_irqn = !((m_flag[k][0] && irq_en[0]) || (m_flag[k][1] && irq_en[1]));
            check($sformatf("model%0d.flag", k),     flag_w[k], {m_flag[k][1], m_flag[k][0]});
            check($sformatf("model%0d.overflow", k), ovf_w[k],  {m_ovf[k][1], m_ovf[k][0]});
            check($sformatf("model%0d.cnt_rd", k),   cnt_w[k],  exp_cnt);
            check($sformatf("model%0d.irq_n", k),    irqn_w[k], exp_irqn);
         end
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_load(input int s, input int v);
      sel = 3'(s); value = 10'(v); load = 1'b1;
      tick_n(1);
      load = 1'b0;
   endtask

   // Counts clock edges until the overflow bit shows, giving up at bound.
   task automatic wait_ovf(input int k, input int ch, input int bound, output int n);
      n = 0;
      do begin
         tick_n(1);
         n++;
      end while (!ovf_w[k][ch] && n < bound);
   endtask

   initial begin
      int n;
      int pulses;
      rst_n = 1'b0; cen = 1'b1; sel = '0; value = '0; load = 1'b0;
      set_run = '0; clr_run = '0; clr_flag = '0; oneshot = '0; irq_en = '0; cascade = '0;
      tick_n(2);
      check("reset.flag_a", flag_w[0], 0);
      check("reset.overflow_a", ovf_w[0], 0);
      check("reset.cnt_rd_a", cnt_w[0], 0);
      check("reset.irq_n_a", irqn_w[0], 1);
      chk_en = 1'b1;
      rst_n  = 1'b1;
      tick_n(2);

      // Auto-reload period: (1024-1020)*64 = 256 ticks.
      irq_en = 2'b01;
      pulse_load(0, 1020);
      wait_ovf(0, 0, 400, n);
      check("period.first", n, 256);
      wait_ovf(0, 0, 400, n);
      check("period.repeat", n, 256);

      // clr_flag held across the wrap edge and the edge after it.
      tick_n(255);
      clr_flag = 2'b01;
      tick_n(1);
      check("clr_on_wrap.flag", flag_w[0][0], 1);
      check("clr_on_wrap.irq_n", irqn_w[0], 0);
      tick_n(1);
      check("clr_after.flag", flag_w[0][0], 0);
      check("clr_after.irq_n", irqn_w[0], 1);
      clr_flag = 2'b00;

      // Only channel 1 enabled onto the IRQ.
      irq_en = 2'b10;
      wait_ovf(0, 0, 400, n);
      check("irq_mask.period", n, 255);
      check("irq_mask.irq_n", irqn_w[0], 1);
      pulse_load(1, 1023);
      wait_ovf(0, 1, 200, n);
      check("irq_ch1.period", n, 64);
      check("irq_ch1.irq_n", irqn_w[0], 0);

      // One-shot on the PW=0 bank: 1024-255 = 769 ticks, then holds.
      oneshot  = 2'b10;
      clr_flag = 2'b10;
      pulse_load(1, 255);
      clr_flag = 2'b00;
      check("oneshot.flag_after_load", flag_w[1][1], 0);
      wait_ovf(1, 1, 1000, n);
      check("oneshot.period", n, 769);
      check("oneshot.flag", flag_w[1][1], 1);
      check("oneshot.cnt_reload", cnt_w[1], 255);
      pulses = 0;
      repeat (100) begin
         tick_n(1);
         pulses += int'(ovf_w[1][1]);
      end
      check("oneshot.no_repeat", pulses, 0);
      check("oneshot.cnt_held", cnt_w[1], 255);

      // Out-of-range select: load ignored, read-back zero.
      pulse_load(5, 7);
      check("bad_sel.cnt_rd_a", cnt_w[0], 0);
      check("bad_sel.cnt_rd_b", cnt_w[1], 0);
      sel = 3'd0;

      // Asynchronous reset with channel 0 at cnt=1023, pre=63.
      irq_en = 2'b11;
      wait_ovf(0, 0, 400, n);
      tick_n(255);
      check("pre_reset.cnt_rd", cnt_w[0], 1023);
      rst_n = 1'b0;
      #1;
      check("async_reset.flag", flag_w[0], 0);
      check("async_reset.overflow", ovf_w[0], 0);
      check("async_reset.cnt_rd", cnt_w[0], 0);
      check("async_reset.irq_n", irqn_w[0], 1);
      tick_n(2);
      rst_n = 1'b1;
      pulses = 0;
      repeat (300) begin
         tick_n(1);
         pulses += int'(ovf_w[0][0]) + int'(ovf_w[0][1]);
      end
      check("after_reset.no_overflow", pulses, 0);

      // Cascade: ch1 start 1022 loaded one cycle before ch0 start 1020.
      oneshot = 2'b00;
      cascade = 2'b10;
      pulse_load(1, 1022);
      pulse_load(0, 1020);
      wait_ovf(0, 1, 700, n);
      check("cascade.ch1_wrap", n, CASC_EN ? 512 : 127);
      check("cascade.ch0_same_cycle", ovf_w[0][0], CASC_EN ? 1 : 0);
      tick_n(4);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
